// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM states for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_DIV = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_muldiv_engine.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// hi/lo present the register pair as it will be after the pending step.
module seq_muldiv_engine #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd_b;
    logic             div_mode;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   trial;

    always_comb begin
        // NOTE: every output gets a default before the branches, so no latch is inferred.
        hi      = acc_hi;
        lo      = acc_lo;
        mul_sum = {1'b0, acc_hi} + {1'b0, opnd_b};
        trial   = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd_b};
        if (div_mode) begin
            // A clear borrow bit means the shifted remainder covers the divisor.
            if (!trial[WIDTH]) begin
                hi = trial[WIDTH-1:0];
                lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else if (acc_lo[0]) begin
            hi = mul_sum[WIDTH:1];
            lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            hi = {1'b0, acc_hi[WIDTH-1:1]};
            lo = {acc_hi[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd_b   <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc_hi   <= '0;
            acc_lo   <= a;
            opnd_b   <= b;
            div_mode <= mode;
        end else if (step) begin
            acc_hi   <= hi;
            acc_lo   <= lo;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, WIDTH-step MUL/DIV,
// with a start/busy/done handshake and registered result and flags.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] opnd1,
    input  logic [WIDTH-1:0] opnd2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zeroFlag,
    output logic             overflow,
    output logic             div_zero
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             iter_div;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] simple_res;
    logic             simple_ovf;
    logic             is_div;
    logic             div_by_zero;
    logic             eng_load;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    assign is_div      = (opcode == OP_DIV);
    assign div_by_zero = is_div && (opnd2 == '0);
    assign eng_load    = (state == ST_IDLE) && start &&
                         ((opcode == OP_MUL) || (is_div && !div_by_zero));

    // Signed overflow is carry-in xor carry-out of the sign bit, which equals
    // "operand signs agree and the result sign differs" (B inverted for SUB).
    always_comb begin
        simple_res = '0;
        simple_ovf = 1'b0;
        if (opcode == OP_SUB)
            sum_ext = {1'b0, opnd1} + {1'b0, ~opnd2} + {{WIDTH{1'b0}}, 1'b1};
        else
            sum_ext = {1'b0, opnd1} + {1'b0, opnd2};
        case (opcode)
            OP_AND: simple_res = opnd1 & opnd2;
            OP_OR:  simple_res = opnd1 | opnd2;
            OP_XOR: simple_res = opnd1 ^ opnd2;
            OP_SLT: simple_res = {{(WIDTH-1){1'b0}}, ($signed(opnd1) < $signed(opnd2))};
            default: begin
                simple_res = sum_ext[WIDTH-1:0];
                simple_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1] ^ opnd1[WIDTH-1] ^
                             (opcode == OP_SUB ? ~opnd2[WIDTH-1] : opnd2[WIDTH-1]);
            end
        endcase
    end

    seq_muldiv_engine #(.WIDTH(WIDTH)) u_engine (
        .clk  (clk),
        .rst  (rst),
        .load (eng_load),
        .step (state == ST_ITER),
        .mode (is_div),
        .a    (opnd1),
        .b    (opnd2),
        .hi   (eng_hi),
        .lo   (eng_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            iter_div <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            out_hi   <= '0;
            zeroFlag <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (eng_load) begin
                            cnt      <= CNT_W'(WIDTH);
                            iter_div <= is_div;
                            state    <= ST_ITER;
                        end else begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            if (div_by_zero) begin
                                out      <= '1;
                                out_hi   <= opnd1;
                                zeroFlag <= 1'b0;
                                overflow <= 1'b0;
                                div_zero <= 1'b1;
                            end else begin
                                out      <= simple_res;
                                out_hi   <= '0;
                                zeroFlag <= (simple_res == '0);
                                overflow <= simple_ovf;
                                div_zero <= 1'b0;
                            end
                        end
                    end
                end
                ST_ITER: begin
                    cnt <= cnt - CNT_W'(1);
                    // The engine's outputs already include this cycle's final step.
                    if (cnt == CNT_W'(1)) begin
                        state    <= ST_FIN;
                        done     <= 1'b1;
                        out      <= eng_lo;
                        out_hi   <= eng_hi;
                        zeroFlag <= (eng_lo == '0);
                        overflow <= !iter_div && (eng_hi != '0);
                        div_zero <= 1'b0;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32.
module tb_seq_alu;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       opcode = 4'h0;
    logic [WIDTH-1:0] opnd1 = '0;
    logic [WIDTH-1:0] opnd2 = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             zero_flag;
    logic             overflow;
    logic             div_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .opnd1    (opnd1),
        .opnd2    (opnd2),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .out_hi   (out_hi),
        .zeroFlag (zero_flag),
        .overflow (overflow),
        .div_zero (div_zero)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ovf;
        logic        zf;
    } vec_t;

    vec_t simple_vecs [10] = '{
        '{4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1},
        '{4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0},
        '{4'b0110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1},
        '{4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0},
        '{4'b0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0},
        '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1},
        '{4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0},
        '{4'b0100, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0},
        '{4'b0101, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0},
        '{4'b1111, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0}
    };

    // Issues one op from just after a rising edge and waits (bounded) for done.
    // Returns the cycle done was seen (start cycle = 0) and the busy-cycle count.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cycles);
        opcode = op; opnd1 = a; opnd2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; opcode = 4'hE; opnd1 = 32'hDEAD_BEEF; opnd2 = 32'h0BAD_F00D;
        lat = 1; busy_cycles = 0;
        while (1) begin
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1 || lat >= 100) break;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL done_timeout op=%h: done=%b after %0d cycles, required 1", op, done, lat);
            errors++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, zero_flag, overflow, div_zero} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b, required 00000", {busy, done, zero_flag, overflow, div_zero});
            errors++;
        end
        checks++;
        if (out !== '0 || out_hi !== '0) begin
            $display("FAIL reset_data: out=%h out_hi=%h, required 0/0", out, out_hi);
            errors++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        int lat, bc;
        run_op(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, lat, bc);
        checks++; if (lat !== 1) begin $display("FAIL add_latency: got %0d, required 1", lat); errors++; end
        checks++; if (out !== 32'h8000_0000) begin $display("FAIL add_out: got %h, required 80000000", out); errors++; end
        checks++; if ({overflow, zero_flag, div_zero} !== 3'b100) begin
            $display("FAIL add_flags: ovf/zf/dz=%b, required 100", {overflow, zero_flag, div_zero}); errors++; end
        checks++; if (out_hi !== '0 || busy !== 1'b1) begin
            $display("FAIL add_hi_busy: out_hi=%h busy=%b, required 0/1", out_hi, busy); errors++; end
    endtask

    task automatic test_simple_ops();
        int lat, bc;
        foreach (simple_vecs[i]) begin
            run_op(simple_vecs[i].op, simple_vecs[i].a, simple_vecs[i].b, lat, bc);
            checks++;
            if (lat !== 1 || out !== simple_vecs[i].exp || out_hi !== '0) begin
                $display("FAIL simple_%0d_out: lat=%0d out=%h out_hi=%h, required 1/%h/0",
                         i, lat, out, out_hi, simple_vecs[i].exp);
                errors++;
            end
            checks++;
            if ({overflow, zero_flag, div_zero} !== {simple_vecs[i].ovf, simple_vecs[i].zf, 1'b0}) begin
                $display("FAIL simple_%0d_flags: ovf/zf/dz=%b, required %b", i,
                         {overflow, zero_flag, div_zero}, {simple_vecs[i].ovf, simple_vecs[i].zf, 1'b0});
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mul();
        int lat, bc;
        run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, lat, bc);
        checks++; if (lat !== 33 || bc !== 33) begin
            $display("FAIL mul_timing: done at %0d busy %0d cycles, required 33/33", lat, bc); errors++; end
        checks++; if (out !== 32'hFFFF_FFFE || out_hi !== 32'h1) begin
            $display("FAIL mul_result: %h_%h, required 00000001_fffffffe", out_hi, out); errors++; end
        checks++; if ({overflow, zero_flag} !== 2'b10) begin
            $display("FAIL mul_flags: ovf/zf=%b, required 10", {overflow, zero_flag}); errors++; end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || out !== 32'hFFFF_FFFE) begin
            $display("FAIL mul_after: done=%b busy=%b out=%h, required 0/0/fffffffe", done, busy, out); errors++; end
        run_op(4'b0010, 32'h0001_0000, 32'h0001_0000, lat, bc);
        checks++; if (out !== '0 || out_hi !== 32'h1 || {overflow, zero_flag} !== 2'b11) begin
            $display("FAIL mul_zero_low: %h_%h ovf/zf=%b, required 00000001_00000000 11",
                     out_hi, out, {overflow, zero_flag}); errors++; end
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        int lat, bc;
        run_op(4'b0111, 32'd100, 32'd7, lat, bc);
        checks++; if (lat !== 33) begin $display("FAIL div_latency: got %0d, required 33", lat); errors++; end
        checks++; if (out !== 32'd14 || out_hi !== 32'd2) begin
            $display("FAIL div_result: q=%0d r=%0d, required 14/2", out, out_hi); errors++; end
        checks++; if ({overflow, zero_flag, div_zero} !== 3'b000) begin
            $display("FAIL div_flags: ovf/zf/dz=%b, required 000", {overflow, zero_flag, div_zero}); errors++; end
        @(posedge clk); #1;
        run_op(4'b0111, 32'd5, 32'd9, lat, bc);
        checks++; if (out !== '0 || out_hi !== 32'd5 || zero_flag !== 1'b1) begin
            $display("FAIL div_small: q=%0d r=%0d zf=%b, required 0/5/1", out, out_hi, zero_flag); errors++; end
        @(posedge clk); #1;
        run_op(4'b0111, 32'd9, 32'd0, lat, bc);
        checks++; if (lat !== 1) begin $display("FAIL divz_latency: got %0d, required 1", lat); errors++; end
        checks++; if (out !== 32'hFFFF_FFFF || out_hi !== 32'd9) begin
            $display("FAIL divz_result: out=%h out_hi=%h, required ffffffff/9", out, out_hi); errors++; end
        checks++; if ({div_zero, overflow, zero_flag} !== 3'b100) begin
            $display("FAIL divz_flags: dz/ovf/zf=%b, required 100", {div_zero, overflow, zero_flag}); errors++; end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start();
        int cyc, lat, bc;
        opcode = 4'b0010; opnd1 = 32'd3; opnd2 = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (cyc == 10) begin
                start = 1'b1; opcode = 4'b0000; opnd1 = 32'd100; opnd2 = 32'd200;
            end else begin
                start = 1'b0;
            end
            if (cyc == 20) begin
                checks++;
                if (out !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
                    $display("FAIL hold_mid_iter: out=%h dz=%b, required ffffffff/1", out, div_zero); errors++; end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checks++; if (cyc !== 33 || done !== 1'b1) begin
            $display("FAIL ignored_latency: done=%b at %0d, required 1 at 33", done, cyc); errors++; end
        checks++; if (out !== 32'd12 || out_hi !== '0 || {overflow, div_zero} !== 2'b00) begin
            $display("FAIL ignored_result: out=%0d hi=%h ovf/dz=%b, required 12/0/00",
                     out, out_hi, {overflow, div_zero}); errors++; end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL done_pulse: done=%b busy=%b, required 0/0", done, busy); errors++; end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(4'b0000, 32'd1, 32'd1, lat, bc);
        checks++; if (lat !== 1 || out !== 32'd2) begin
            $display("FAIL b2b_add: lat=%0d out=%0d, required 1/2", lat, out); errors++; end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, bc, cyc;
        bit seen;
        opcode = 4'b0111; opnd1 = 32'd1000; opnd2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc < 15; cyc++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || out !== '0 || out_hi !== '0) begin
            $display("FAIL reset_mid: busy=%b done=%b out=%h hi=%h, required 0/0/0/0", busy, done, out, out_hi);
            errors++; end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(4'b0000, 32'd1, 32'd2, lat, bc);
        checks++; if (lat !== 1 || out !== 32'd3) begin
            $display("FAIL post_reset_add: lat=%0d out=%0d, required 1/3", lat, out); errors++; end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i > 0 && done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL aborted_div: stray done=%b busy=%b, required 0/0", seen, busy); errors++; end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add_overflow();
        @(posedge clk); #1;
        test_simple_ops();
        test_mul();
        test_div();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle ALU that succeeds the single-cycle combinational ALU in the multi-cycle MIPS datapath.
- Single-cycle ops (ADD/SUB/AND/OR/XOR/SLT) complete with registered results.
- Unsigned MUL and DIV run on an iterative shift-add / restoring engine over WIDTH cycles.
- A start/busy/done handshake lets the control FSM stall until the result is valid.

Parameters:
- WIDTH, 32: operand and result width; must be ≥ 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- opcode  in  4  operation select; captured with start.
- opnd1  in  WIDTH  operand A; captured with start.
- opnd2  in  WIDTH  operand B; captured with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result and flag outputs valid from this cycle.
- out  out  WIDTH  result, low word (MUL low product, DIV quotient).
- out_hi  out  WIDTH  MUL high product, DIV remainder; 0 for other ops.
- zeroFlag  out  1  out == 0.
- overflow  out  1  signed overflow for ADD/SUB; for MUL, out_hi != 0; else 0.
- div_zero  out  1  DIV with opnd2 == 0.

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state IDLE; all outputs 0; the iteration is aborted and the captured operands are discarded.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 AND, 0100 OR: encodings kept from the previous ALU.
  - 0101 XOR.
  - 0110 SLT: signed compare, out = {0…,1} when A < B.
  - 0111 DIV.
  - Any other code behaves as ADD.
- FSM states: IDLE, ITER, FIN.
  - IDLE and start=1, opcode ∉ {MUL, DIV}, or DIV with opnd2 == 0: compute → FIN.
  - IDLE and start=1, opcode ∈ {MUL, DIV} with a nonzero divisor: load the engine, counter = WIDTH → ITER.
  - ITER: one shift step per cycle, counter decrements; when the counter reaches 1 on the final step → FIN.
  - FIN: outputs registered, done=1 for exactly this cycle → IDLE.
- Latency (start cycle = cycle 0):
  - Simple ops and DIV-by-zero: done at cycle 1.
  - MUL and DIV: done at cycle WIDTH+1.
- busy: 1 in ITER and FIN, 0 in IDLE.
- start is ignored in ITER and FIN; operands may change freely after the capture cycle.
- start may be asserted in the cycle immediately after done, giving back-to-back operation.
- Hold rule: out, out_hi and the flags hold their last values until the next FIN. They update only in FIN, never mid-iteration.
- Width rules:
  - ADD/SUB use a WIDTH+1 internal sum.
  - Signed overflow = operand signs agree (SUB: A and ~B) and the result sign differs.
  - MUL: unsigned 2·WIDTH product, {out_hi, out}.
  - DIV: unsigned restoring division; out = quotient, out_hi = remainder.
- DIV by zero: out = all ones, out_hi = opnd1, div_zero = 1, overflow = 0.
- zeroFlag evaluates out only, including for MUL and DIV.
- div_zero is cleared by every FIN of a non-faulting op.

Decomposition:
- Package alu_pkg:
  - Opcode localparams: OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_DIV.
  - FSM state encoding: ST_IDLE, ST_ITER, ST_FIN.
- Sub-module seq_muldiv_engine:
  - Holds the WIDTH-step shift-add multiplier / restoring divider datapath, with load/step/mode inputs and hi/lo outputs.
  - The top module owns the FSM, counter, simple ops and flags.

Test Plan (WIDTH=32):
- ADD, overflow: start ADD 0x7FFFFFFF + 0x00000001 → done at cycle 1; out = 0x80000000, overflow = 1, zeroFlag = 0.
- SUB, zero result: start SUB 5 − 5 → out = 0, zeroFlag = 1, overflow = 0. Then SLT −1 vs 1 → out = 1.
- MUL: 0xFFFFFFFF × 2 → busy for 33 cycles; done exactly at cycle 33; out = 0xFFFFFFFE, out_hi = 1, overflow = 1.
- DIV: 100 / 7 → done at cycle 33; out = 14, out_hi = 2. Then DIV 9 / 0 → done at cycle 1; out = 0xFFFFFFFF, out_hi = 9, div_zero = 1.
- Ignored start: start MUL 3 × 4, pulse start with ADD at cycle 10 → ADD ignored; result 12 at cycle 33. A back-to-back start in the cycle after done is accepted.
- Reset mid-operation: assert rst at cycle 15 of a DIV → busy, done and out go to 0 immediately. After release, a new ADD 1 + 2 returns 3 at cycle 1.
